// File: rtl/ethernet_irq_coalescer.sv
// ethernet_irq_coalescer: per-channel event coalescing (count threshold + timeout) into a sticky, maskable interrupt
// Ports:
//   clk_i, reset_n_i        core clock, asynchronous active-low reset
//   event_i                 per-channel status level, rising edge = one event
//   cfg_v_i, cfg_chan_i     config write strobe and target channel
//   cfg_enable_i            channel enable
//   cfg_threshold_i         events per interrupt (0 behaves as 1)
//   cfg_timeout_i           cycles before a partial batch fires (0 = timer off)
//   clear_v_i, clear_mask_i write-1-to-clear pending bits
//   pending_o, irq_o        pending & enable per channel, and their OR
//   count_o                 per-channel event counts, channel c at [c*count_width_p +: count_width_p]
module ethernet_irq_coalescer #(
    parameter int num_chan_p    = 4,
    parameter int count_width_p = 8,
    parameter int timer_width_p = 16,
    localparam int chan_width_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_chan_p-1:0]               event_i,
    input  logic                                cfg_v_i,
    input  logic [chan_width_lp-1:0]            cfg_chan_i,
    input  logic                                cfg_enable_i,
    input  logic [count_width_p-1:0]            cfg_threshold_i,
    input  logic [timer_width_p-1:0]            cfg_timeout_i,
    input  logic                                clear_v_i,
    input  logic [num_chan_p-1:0]               clear_mask_i,
    output logic [num_chan_p-1:0]               pending_o,
    output logic                                irq_o,
    output logic [num_chan_p*count_width_p-1:0] count_o
);
    logic [num_chan_p-1:0]                     event_r_q, enable_q, enable_d, pending_q, pending_d, rise;
    logic [num_chan_p-1:0][count_width_p-1:0] threshold_q, threshold_d, count_q, count_d, eff_thr;
    logic [num_chan_p-1:0][timer_width_p-1:0] timeout_q, timeout_d, timer_q, timer_d;
    always_comb begin
        rise = event_i & ~event_r_q;
        for (int c = 0; c < num_chan_p; c++) begin
            eff_thr[c]     = (threshold_q[c] == '0) ? count_width_p'(1) : threshold_q[c];
            enable_d[c]    = enable_q[c];
            threshold_d[c] = threshold_q[c];
            timeout_d[c]   = timeout_q[c];
            count_d[c]     = count_q[c];
            timer_d[c]     = timer_q[c];
            pending_d[c]   = pending_q[c] & ~(clear_v_i & clear_mask_i[c]);
            // Out-of-range channel indices never match, so such writes fall away.
            if (cfg_v_i && cfg_chan_i == chan_width_lp'(c)) begin
                enable_d[c]    = cfg_enable_i;
                threshold_d[c] = cfg_threshold_i;
                timeout_d[c]   = cfg_timeout_i;
            end
            // Decisions use the registered config, so a same-cycle write only affects later cycles.
            if (!enable_q[c]) begin
                count_d[c] = '0;
                timer_d[c] = '0;
            end else if (rise[c] && ({1'b0, count_q[c]} + 1'b1 >= {1'b0, eff_thr[c]})) begin
                pending_d[c] = 1'b1;
                count_d[c]   = '0;
                timer_d[c]   = '0;
            end else if (rise[c]) begin
                count_d[c] = (&count_q[c]) ? count_q[c] : count_q[c] + 1'b1;
                // The timer measures the oldest event of the batch, so later rises keep it running.
                timer_d[c] = (count_q[c] == '0 || timeout_q[c] == '0) ? '0 : timer_q[c] + 1'b1;
            end else if (count_q[c] != '0 && timeout_q[c] != '0 && timer_q[c] == timeout_q[c] - 1'b1) begin
                pending_d[c] = 1'b1;
                count_d[c]   = '0;
                timer_d[c]   = '0;
            end else begin
                timer_d[c] = (count_q[c] != '0 && timeout_q[c] != '0) ? timer_q[c] + 1'b1 : '0;
            end
        end
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            event_r_q   <= '0;
            enable_q    <= '0;
            threshold_q <= {num_chan_p{count_width_p'(1)}};
            timeout_q   <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            pending_q   <= '0;
        end else begin
            event_r_q   <= event_i;
            enable_q    <= enable_d;
            threshold_q <= threshold_d;
            timeout_q   <= timeout_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            pending_q   <= pending_d;
        end
    end
    assign pending_o = pending_q & enable_q;
    assign irq_o     = |pending_o;
    assign count_o   = count_q;
endmodule

// File: tb/tb_ethernet_irq_coalescer.sv
// tb_ethernet_irq_coalescer: vector table plus hand sequences with a scoreboard; a 3-channel copy checks out-of-range config writes
module tb_ethernet_irq_coalescer;
    typedef struct {
        logic [3:0]  ev;
        logic        cv;
        logic [1:0]  ch;
        logic        en;
        logic [7:0]  thr;
        logic [15:0] to;
        logic        clv;
        logic [3:0]  cm;
        logic [3:0]  ep;
        logic [31:0] ec;
        int          tag;
    } vec_t;
    typedef struct {
        logic [3:0]  ep;
        logic [31:0] ec;
        int          tag;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  event_i = '0, clear_mask = '0;
    logic        cfg_v = 1'b0, cfg_en = 1'b0, clear_v = 1'b0;
    logic [1:0]  cfg_chan = '0;
    logic [7:0]  cfg_thr = '0;
    logic [15:0] cfg_to = '0;
    logic [3:0]  pending;
    logic        irq, irq2;
    logic [31:0] count;
    logic [2:0]  pend2;
    logic [23:0] cnt2;
    int          n_checks = 0, n_err = 0;
    exp_t        sb[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    ethernet_irq_coalescer dut (
        .clk_i(clk), .reset_n_i(rst_n), .event_i(event_i), .cfg_v_i(cfg_v), .cfg_chan_i(cfg_chan),
        .cfg_enable_i(cfg_en), .cfg_threshold_i(cfg_thr), .cfg_timeout_i(cfg_to), .clear_v_i(clear_v),
        .clear_mask_i(clear_mask), .pending_o(pending), .irq_o(irq), .count_o(count)
    );

    // Same stimulus; every write aimed at channel 3 is out of range for this copy.
    ethernet_irq_coalescer #(.num_chan_p(3)) dut3 (
        .clk_i(clk), .reset_n_i(rst_n), .event_i(event_i[2:0]), .cfg_v_i(cfg_v), .cfg_chan_i(cfg_chan),
        .cfg_enable_i(cfg_en), .cfg_threshold_i(cfg_thr), .cfg_timeout_i(cfg_to), .clear_v_i(clear_v),
        .clear_mask_i(clear_mask[2:0]), .pending_o(pend2), .irq_o(irq2), .count_o(cnt2)
    );

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, tag, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] ev, input logic cv, input logic [1:0] ch, input logic en,
                                input logic [7:0] thr, input logic [15:0] to, input logic clv,
                                input logic [3:0] cm, input logic [3:0] ep, input logic [31:0] ec, input int tag);
        vec_t v;
        v.ev = ev; v.cv = cv; v.ch = ch; v.en = en; v.thr = thr; v.to = to;
        v.clv = clv; v.cm = cm; v.ep = ep; v.ec = ec; v.tag = tag;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        event_i = v.ev; cfg_v = v.cv; cfg_chan = v.ch; cfg_en = v.en; cfg_thr = v.thr; cfg_to = v.to;
        clear_v = v.clv; clear_mask = v.cm;
        sb.push_back('{v.ep, v.ec, v.tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pending", e.tag, 32'(pending), 32'(e.ep));
        chk("irq", e.tag, 32'(irq), 32'(|e.ep));
        chk("count", e.tag, count, e.ec);
        chk("pending_3ch", e.tag, 32'(pend2), 32'(e.ep[2:0]));
        chk("count_3ch", e.tag, 32'(cnt2), 32'(e.ec[23:0]));
    endtask

    initial begin
        int cnt;
        logic p;
        // reset held with all event levels high
        event_i = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pending", 0, 32'(pending), 0);
        chk("reset_irq", 0, 32'(irq), 0);
        chk("reset_count", 0, count, 0);
        chk("reset_pending_3ch", 0, 32'(pend2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        //                 ev    cv ch en thr to clv cm       ep       ec
        tbl.push_back(mk(4'hF, 1, 0, 1, 1, 0, 0, 4'h0, 4'b0000, 32'h0, 1));
        tbl.push_back(mk(4'hF, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0000, 32'h0, 2));
        tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0000, 32'h0, 3));
        tbl.push_back(mk(4'h0, 1, 1, 1, 3, 0, 0, 4'h0, 4'b0000, 32'h0, 4));
        tbl.push_back(mk(4'h2, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0000, 32'h100, 5));
        tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0000, 32'h100, 6));
        tbl.push_back(mk(4'h2, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0000, 32'h200, 7));
        tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0000, 32'h200, 8));
        tbl.push_back(mk(4'h2, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0010, 32'h0, 9));
        tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0010, 32'h0, 10));
        tbl.push_back(mk(4'h1, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0011, 32'h0, 11));
        tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 1, 4'h2, 4'b0001, 32'h0, 12));
        tbl.push_back(mk(4'h1, 0, 0, 0, 0, 0, 1, 4'h1, 4'b0001, 32'h0, 13));
        tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 1, 4'h1, 4'b0000, 32'h0, 14));
        tbl.push_back(mk(4'h0, 1, 3, 1, 2, 0, 0, 4'h0, 4'b0000, 32'h0, 15));
        tbl.push_back(mk(4'h8, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0000, 32'h0100_0000, 16));
        tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0000, 32'h0100_0000, 17));
        tbl.push_back(mk(4'h8, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1000, 32'h0, 18));
        tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1000, 32'h0, 19));
        tbl.push_back(mk(4'h8, 0, 0, 0, 0, 0, 0, 4'h0, 4'b1000, 32'h0100_0000, 20));
        tbl.push_back(mk(4'h0, 1, 3, 0, 2, 0, 0, 4'h0, 4'b0000, 32'h0100_0000, 21));
        tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0000, 32'h0, 22));
        tbl.push_back(mk(4'h0, 1, 3, 1, 2, 0, 0, 4'h0, 4'b1000, 32'h0, 23));
        tbl.push_back(mk(4'h0, 0, 0, 0, 0, 0, 1, 4'h8, 4'b0000, 32'h0, 24));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        // timeout: ch2 thr=8 timeout=10, rise at k=0, extra rise at k=5, fire visible after step 10
        apply(mk(4'h0, 1, 2, 1, 8, 10, 0, 4'h0, 4'b0000, 32'h0, 100));
        for (int k = 0; k <= 10; k++)
            apply(mk((k == 0 || k == 5) ? 4'h4 : 4'h0, 0, 0, 0, 0, 0, 0, 4'h0,
                     (k == 10) ? 4'b0100 : 4'b0000,
                     (k == 10) ? 32'h0 : (k < 5) ? 32'h1_0000 : 32'h2_0000, 101 + k));
        apply(mk(4'h0, 0, 0, 0, 0, 0, 1, 4'h4, 4'b0000, 32'h0, 120));
        // threshold 255 on ch0 with 300 rises
        apply(mk(4'h0, 1, 0, 1, 255, 0, 0, 4'h0, 4'b0000, 32'h0, 200));
        cnt = 0;
        p = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            if (cnt + 1 >= 255) begin
                p = 1'b1;
                cnt = 0;
            end else cnt++;
            apply(mk(4'h1, 0, 0, 0, 0, 0, 0, 4'h0, {3'b000, p}, 32'(cnt), 1000 + i));
            apply(mk(4'h0, 0, 0, 0, 0, 0, 0, 4'h0, {3'b000, p}, 32'(cnt), 2000 + i));
        end
        chk("sat_final_count", 300, count, 32'd45);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
